// File: rtl/dataset_load_ctrl.sv
// dataset_load_ctrl: loads a training dataset from a 1-bit serial stream into the dataset RAM.
// Each record of (feat+1) LENGTH-bit words is packed MSB-justified into one DATA_WIDTH row and
// written with a ready handshake. When the last record has been stored, done rises and the RAM
// is released to the compute engine.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-low reset
//   start             begin a load (sampled in IDLE or DONE only)
//   num_dp, feat      last record index and feature count, latched on start
//   ser_valid, ser    serial bit stream, first bit of a record lands at bit `base`
//   ram_ready         RAM accepts the current write
//   ram_we/addr/data  write request, held stable until accepted
//   busy, done, err   load in progress, load complete, sticky overrun
module dataset_load_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_dp,
    input  logic [3:0]            feat,
    input  logic                  ser_valid,
    input  logic                  ser,
    input  logic                  ram_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StWrite, StDone} state_t;

    state_t                state_q, state_d;
    logic [3:0]            feat_q, feat_d;
    logic [ADDR_WIDTH-1:0] num_dp_q, num_dp_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  ram_we_q, ram_we_d;
    logic                  err_q, err_d;

    logic [CNT_W-1:0]      rec_bits;
    logic [CNT_W-1:0]      base;
    logic [CNT_W-1:0]      bit_idx;

    assign rec_bits = CNT_W'(LENGTH) * (CNT_W'(feat_q) + CNT_W'(1));
    assign base     = CNT_W'(DATA_WIDTH) - rec_bits;
    assign bit_idx  = base + bit_cnt_q;

    always_comb begin
        state_d    = state_q;
        feat_d     = feat_q;
        num_dp_d   = num_dp_q;
        bit_cnt_d  = bit_cnt_q;
        addr_cnt_d = addr_cnt_q;
        shift_d    = shift_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    feat_d     = feat;
                    num_dp_d   = num_dp;
                    bit_cnt_d  = '0;
                    addr_cnt_d = '0;
                    shift_d    = '0;
                    err_d      = 1'b0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (ser_valid) begin
                    shift_d[bit_idx[IDX_W-1:0]] = ser;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == rec_bits - CNT_W'(1)) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Bits arriving while the row is parked are dropped.
                if (ser_valid) begin
                    err_d = 1'b1;
                end
                // ram_ready only counts once the request is actually presented.
                if (ram_we_q && ram_ready) begin
                    if (addr_cnt_q == num_dp_q) begin
                        state_d = StDone;
                    end else begin
                        addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        state_d    = StShift;
                    end
                end
            end
        endcase

        // Request rises one cycle after entering WRITE and falls on acceptance.
        ram_we_d = (state_q == StWrite) && (state_d == StWrite);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            feat_q     <= '0;
            num_dp_q   <= '0;
            bit_cnt_q  <= '0;
            addr_cnt_q <= '0;
            shift_q    <= '0;
            ram_we_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            feat_q     <= feat_d;
            num_dp_q   <= num_dp_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            shift_q    <= shift_d;
            ram_we_q   <= ram_we_d;
            err_q      <= err_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = addr_cnt_q;
    assign ram_data = shift_q;
    assign busy     = (state_q == StShift) || (state_q == StWrite);
    assign done     = (state_q == StDone);
    assign err      = err_q;

endmodule
